// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int          INSTR_W          = 32;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO; flush wins over push and pop.
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Storage is reset so the head reads as zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, single-outstanding imem requests, prefetch FIFO.
// Optional FETCH_PERF_CNT_EN adds FetchCnt/StallCnt performance counters.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(DEFAULT_RESET_PC),
    parameter int                FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               ImemReq,
    output logic [ADDR_W-1:0]  ImemAddr,
    input  logic               ImemAck,
    input  logic [INSTR_W-1:0] ImemRdata,
    input  logic               RedirectD,
    input  logic [ADDR_W-1:0]  RedirectPCD,
    output logic               InstrValidF,
    output logic [INSTR_W-1:0] InstrF,
    output logic [ADDR_W-1:0]  PCPlus4F,
    input  logic               InstrReadyD
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]        FetchCnt,
    output logic [31:0]        StallCnt
`endif
);

    // state | meaning
    // FETCH | idle or zero-wait fetching; request when FIFO has room
    // WAIT  | request outstanding, holding ImemReq/ImemAddr
    // DRAIN | redirected while outstanding; swallow the stale ack

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int ENT_W = INSTR_W + ADDR_W;

    fetch_state_t      state;
    fetch_state_t      next_state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_next;
    logic [ADDR_W-1:0] pc_plus4;
    logic              run;
    logic              imem_req;
    logic              push;
    logic              pop;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_empty;
    logic              unused_full;
    logic              unused_bits;
    logic [ENT_W-1:0]  fifo_head;

    assign pc_plus4    = pc + ADDR_W'(4);
    assign unused_bits = ^RedirectPCD[1:0];

    // run holds ImemReq low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
            pc    <= RESET_PC;
            run   <= 1'b0;
        end else begin
            state <= next_state;
            pc    <= pc_next;
            run   <= 1'b1;
        end
    end

    always_comb begin
        next_state = state;
        imem_req   = 1'b0;
        push       = 1'b0;
        pc_next    = pc;
        case (state)
            FETCH: begin
                imem_req = run && (fifo_count < CNT_W'(FIFO_DEPTH)) && !RedirectD;
                if (imem_req) begin
                    if (ImemAck) begin
                        push = 1'b1;
                    end else begin
                        next_state = WAIT;
                    end
                end
            end
            WAIT: begin
                imem_req = 1'b1;
                if (ImemAck) begin
                    push       = !RedirectD;
                    next_state = FETCH;
                end else if (RedirectD) begin
                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (ImemAck) begin
                    next_state = FETCH;
                end
            end
            default: next_state = FETCH;
        endcase
        if (RedirectD) begin
            pc_next = {RedirectPCD[ADDR_W-1:2], 2'b00};
        end else if (push) begin
            pc_next = pc_plus4;
        end
    end

    assign ImemReq  = imem_req;
    assign ImemAddr = pc;
    assign pop      = !fifo_empty && InstrReadyD;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENT_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (RedirectD),
        .wdata ({ImemRdata, pc_plus4}),
        .rdata (fifo_head),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (unused_full)
    );

    assign InstrValidF = !fifo_empty;
    assign InstrF      = fifo_head[ENT_W-1:ADDR_W];
    assign PCPlus4F    = fifo_head[ADDR_W-1:0];

`ifdef FETCH_PERF_CNT_EN
    // A pop coinciding with a redirect is discarded, so it is not counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            FetchCnt <= '0;
            StallCnt <= '0;
        end else begin
            if (pop && !RedirectD) begin
                FetchCnt <= FetchCnt + 32'd1;
            end
            if (InstrReadyD && fifo_empty) begin
                StallCnt <= StallCnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized self-checking bench for fetch_unit against a queue-based model.
module tb_fetch_unit;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ImemReq;
    logic [31:0] ImemAddr;
    logic        ImemAck = 1'b0;
    logic [31:0] ImemRdata = '0;
    logic        RedirectD = 1'b0;
    logic [31:0] RedirectPCD = '0;
    logic        InstrValidF;
    logic [31:0] InstrF;
    logic [31:0] PCPlus4F;
    logic        InstrReadyD = 1'b0;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] FetchCnt;
    logic [31:0] StallCnt;
`endif

    fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0), .FIFO_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ImemReq     (ImemReq),
        .ImemAddr    (ImemAddr),
        .ImemAck     (ImemAck),
        .ImemRdata   (ImemRdata),
        .RedirectD   (RedirectD),
        .RedirectPCD (RedirectPCD),
        .InstrValidF (InstrValidF),
        .InstrF      (InstrF),
        .PCPlus4F    (PCPlus4F),
        .InstrReadyD (InstrReadyD)
`ifdef FETCH_PERF_CNT_EN
        ,
        .FetchCnt    (FetchCnt),
        .StallCnt    (StallCnt)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // model state: expected FIFO contents {instr, pc+4} and next fetch PC
    logic [63:0] q[$];
    logic [31:0] m_pc;
    logic        running, outstanding, discarding;
    logic [31:0] m_fcnt, m_scnt;

    // memory environment
    logic        mem_busy;
    int          mem_lat;
    logic [31:0] mem_addr;
    int          lat_min, lat_max, ready_pct;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    task automatic model_reset();
        q.delete();
        m_pc        = 32'h0;
        running     = 1'b0;
        outstanding = 1'b0;
        discarding  = 1'b0;
        mem_busy    = 1'b0;
        mem_lat     = 0;
        m_fcnt      = '0;
        m_scnt      = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n       = 1'b0;
        RedirectD   = 1'b0;
        ImemAck     = 1'b0;
        InstrReadyD = 1'b0;
        model_reset();
        #1;
        check("rst_req", {63'd0, ImemReq}, 64'd0);
        check("rst_valid", {63'd0, InstrValidF}, 64'd0);
        check("rst_instr", {32'd0, InstrF}, 64'd0);
        check("rst_pc4", {32'd0, PCPlus4F}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_req", {63'd0, ImemReq}, 64'd0);
        @(posedge clk);
        running = 1'b1;
    endtask

    task automatic step(input logic redir, input logic [31:0] rpc);
        logic        exp_req, resp, spur, pop, was_empty;
        logic [31:0] data;
        @(negedge clk);
        RedirectD   = redir;
        RedirectPCD = rpc;
        InstrReadyD = ($urandom_range(99) < ready_pct);
        ImemAck     = 1'b0;
        #1;
        exp_req = outstanding ? !discarding
                              : (running && (q.size() < DEPTH) && !redir);
        check("imem_req", {63'd0, ImemReq}, {63'd0, exp_req});
        if (exp_req) check("imem_addr", {32'd0, ImemAddr}, {32'd0, m_pc});
        check("instr_valid", {63'd0, InstrValidF}, {63'd0, q.size() != 0});
        if (q.size() != 0) begin
            check("instr", {32'd0, InstrF}, {32'd0, q[0][63:32]});
            check("pc_plus4", {32'd0, PCPlus4F}, {32'd0, q[0][31:0]});
        end
        if (!mem_busy && ImemReq) begin
            mem_busy = 1'b1;
            mem_lat  = $urandom_range(lat_max, lat_min);
            mem_addr = ImemAddr;
        end
        resp = 1'b0;
        if (mem_busy) begin
            if (mem_lat == 0) begin
                resp     = 1'b1;
                mem_busy = 1'b0;
            end else begin
                mem_lat--;
            end
        end
        spur      = !resp && !ImemReq && !mem_busy && ($urandom_range(7) == 0);
        data      = mem_word(mem_addr);
        ImemAck   = resp || spur;
        ImemRdata = resp ? data : $urandom();
        was_empty = (q.size() == 0);
        pop       = !was_empty && InstrReadyD;
        if (!redir && pop) m_fcnt++;
        if (InstrReadyD && was_empty) m_scnt++;
        if (redir) begin
            q.delete();
            if (outstanding || exp_req) begin
                outstanding = !resp;
                discarding  = !resp;
            end
            m_pc = {rpc[31:2], 2'b00};
        end else begin
            if (pop) void'(q.pop_front());
            if (resp) begin
                if (!discarding) begin
                    q.push_back({data, m_pc + 32'd4});
                    m_pc = m_pc + 32'd4;
                end
                outstanding = 1'b0;
                discarding  = 1'b0;
            end else if (exp_req) begin
                outstanding = 1'b1;
            end
        end
    endtask

    initial begin
        lat_min = 0; lat_max = 0; ready_pct = 100;
        do_reset();

        // zero-wait memory, consumer always ready
        repeat (8) step(1'b0, 32'h0);

        // consumer stalled: FIFO fills, requests stop, then resume
        ready_pct = 0;
        repeat (8) step(1'b0, 32'h0);
        check("full_no_req", {63'd0, ImemReq}, 64'd0);
        ready_pct = 100;
        repeat (8) step(1'b0, 32'h0);

        // 3-cycle memory latency
        lat_min = 2; lat_max = 2;
        repeat (12) step(1'b0, 32'h0);

        // redirect to 0x100 while a request waits
        for (int i = 0; i < 20 && !(outstanding && !discarding); i++) step(1'b0, 32'h0);
        step(1'b1, 32'h100);
        repeat (10) step(1'b0, 32'h0);

        // redirect to 0x203 on the ack cycle together with a pop
        lat_min = 1; lat_max = 1;
        for (int i = 0; i < 20 && !(outstanding && !discarding && q.size() != 0); i++)
            step(1'b0, 32'h0);
        step(1'b1, 32'h203);
        repeat (6) step(1'b0, 32'h0);

        // random traffic with a mid-run reset
        lat_min = 0; lat_max = 3; ready_pct = 70;
        for (int i = 0; i < 3000; i++) begin
            logic        r;
            logic [31:0] rp;
            if (i == 1500) do_reset();
            r  = ($urandom_range(19) == 0);
            rp = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 + $urandom_range(15)) : $urandom();
            step(r, rp);
            if (i % 500 == 0) ready_pct = $urandom_range(100, 20);
        end

`ifdef FETCH_PERF_CNT_EN
        #1;
        check("fetch_cnt", {32'd0, FetchCnt}, {32'd0, m_fcnt});
        check("stall_cnt", {32'd0, StallCnt}, {32'd0, m_scnt});
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction-fetch stage replacing the fixed single-cycle IF stage. It holds the PC and issues one-outstanding requests to an instruction memory that may take a variable number of cycles. Returned words go into a prefetch FIFO that the decode stage drains through a valid/ready handshake. Branch redirects from decode flush the FIFO and discard any in-flight response.

## Interface
- ADDR_W, 32, PC and memory address width (≥ 8).
- RESET_PC, 0, PC value loaded on reset; bits [1:0] must be 0.
- FIFO_DEPTH, 4, prefetch entries; power of two, ≥ 2.

- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ImemReq  out  1  request valid; held high until ImemAck.
- ImemAddr  out  ADDR_W  word-aligned fetch address (bits [1:0] = 0); stable while ImemReq high.
- ImemAck  in  1  response valid; may coincide with the first ImemReq cycle (zero-wait).
- ImemRdata  in  32  instruction word, valid with ImemAck.
- RedirectD  in  1  branch/jump taken in decode.
- RedirectPCD  in  ADDR_W  new PC; bits [1:0] ignored and treated as 0.
- InstrValidF  out  1  FIFO head valid.
- InstrF  out  32  FIFO head instruction.
- PCPlus4F  out  ADDR_W  address of FIFO head + 4.
- InstrReadyD  in  1  decode accepts head; pop when InstrValidF && InstrReadyD.

## Operation
- State machine has three states: FETCH, WAIT, DRAIN.
- Reset state:
  - PC = RESET_PC, FIFO empty, state FETCH.
  - ImemReq = 0, InstrValidF = 0.
  - InstrF = 0, PCPlus4F = 0.
- FETCH:
  - ImemReq = (count < FIFO_DEPTH) && !RedirectD.
  - If ImemReq && ImemAck: push {ImemRdata, PC+4}, PC <= PC+4, stay in FETCH.
  - If ImemReq && !ImemAck: go to WAIT.
- WAIT:
  - ImemReq = 1, ImemAddr = PC.
  - On ImemAck: push, PC <= PC+4, go to FETCH.
- DRAIN:
  - ImemReq = 0.
  - On ImemAck: discard the data, go to FETCH.
- Redirect has priority over every other event:
  - FIFO is cleared and PC <= {RedirectPCD[ADDR_W-1:2], 2'b00}.
  - A pop in the same cycle is ignored, and nothing is pushed that cycle.
  - From WAIT with no ImemAck that cycle: go to DRAIN.
  - From WAIT with ImemAck that cycle: the data is discarded, go to FETCH.
  - From FETCH or DRAIN: stay in the same state, or go to FETCH if DRAIN sees ImemAck.
- Space reservation: a request is issued only while count < FIFO_DEPTH. Only one request is ever outstanding, and pops only free space, so a push never hits a full FIFO.
- A simultaneous push and pop leaves count unchanged.
- The FIFO has no bypass path.
- PC arithmetic is modulo 2^ADDR_W; the wrap from all-ones-minus-3 to 0 is silent.
- Reset asserted mid-operation aborts everything. A late ImemAck after reset while in FETCH with ImemReq low is ignored.

## Timing
- Reset release to the first ImemReq: 1 cycle. ImemReq is high in the first clk edge's cycle after rst_n rises.
- ImemAck to InstrValidF: 1 cycle (registered FIFO).
- Zero-wait memory sustains one push per cycle. With a consumer always ready, throughput is 1 instruction/cycle.
- Redirect to the first request at the new PC:
  - Next cycle if no response is outstanding.
  - Otherwise the cycle after the draining ImemAck.
- Redirect to the first InstrValidF at the new PC: at least 2 cycles.
- ImemReq and ImemAddr are combinational from state, PC, count and RedirectD. InstrValidF, InstrF and PCPlus4F come directly from registers.

## Configuration
- FETCH_PERF_CNT_EN defined:
  - Adds outputs FetchCnt (32) and StallCnt (32), both reset to 0 and wrapping at 2^32.
  - FetchCnt increments on every accepted pop.
  - StallCnt increments on every cycle with InstrReadyD && !InstrValidF.
- FETCH_PERF_CNT_EN undefined: both ports and both counters are absent.

## Structure
- Package fetch_pkg holds:
  - The state encoding: FETCH=2'd0, WAIT=2'd1, DRAIN=2'd2.
  - A default RESET_PC constant.
  - The 32-bit instruction width constant.
- Sub-module fetch_fifo: a synchronous FIFO with DEPTH and WIDTH parameters.
  - Ports: push, pop, flush, count, empty/full.
  - Flush has priority over push and pop.
  - One instance holds {instr, pc_plus4}.

## Test plan
- Reset, zero-wait memory, InstrReadyD=1:
  - ImemAddr sequence is 0x0, 0x4, 0x8.
  - InstrF follows the memory image one cycle later.
  - PCPlus4F is 0x4, 0x8, 0xC.
- InstrReadyD=0 with FIFO_DEPTH=4:
  - Exactly 4 acks are pushed, then ImemReq stays 0.
  - Raising InstrReadyD resumes fetching at 0x10.
- Memory with 3-cycle latency:
  - ImemReq is held 3 cycles and ImemAddr stays stable.
  - Throughput is one instruction per 3 cycles.
- RedirectD to 0x100 in WAIT, ack 2 cycles later:
  - The stale ack is discarded.
  - The next ImemAddr is 0x100.
  - No stale instruction ever reaches InstrF.
- RedirectD to 0x203 in the same cycle as ImemAck and a pop:
  - FIFO becomes empty and the data is dropped.
  - The next ImemAddr is 0x200.
- With FETCH_PERF_CNT_EN: 10 pops and 3 empty-while-ready cycles give FetchCnt=10 and StallCnt=3.
